// File: rtl/samplerz_pkg.sv
// Shared constants and types for the SamplerZ BerExp accept/reject controller.
//   Z_W          : width of the signed candidate integer z
//   BER_LATENCY  : BerExp din-accept to dout_val latency, built from the
//                  latencies of its exp, multiply and floor sub-stages plus
//                  one output register
//   z_t          : signed candidate type
package samplerz_pkg;

  localparam int Z_W         = 16;
  localparam int EXP_LAT     = 8;
  localparam int MULT_LAT    = 2;
  localparam int FLOOR_LAT   = 1;
  localparam int BER_LATENCY = EXP_LAT + MULT_LAT + FLOOR_LAT + 1;

  typedef logic signed [Z_W-1:0] z_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
//   clk, rst      : clock, synchronous active-low reset
//   push, din     : write strobe and data (caller never pushes when full)
//   pop           : read strobe (caller never pops when empty)
//   dout          : head entry, valid whenever count != 0
//   count         : current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo_fwft #(
  parameter int W     = 16,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only observed after it was written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/samplerz_berexp_ctrl.sv
// Accept/reject controller sitting after BerExp in the SamplerZ rejection loop.
// Candidates (z, ccs, x) are handed to BerExp together with one random byte;
// z waits in a pending FIFO until its in-order verdict w returns. Accepted z
// go to an output ready/valid stream, rejects produce a one-cycle reject_o.
// BerExp cannot be stalled on its output, so issue is credit-limited: a
// candidate is only issued while pending + accepted-not-consumed < DEPTH,
// which guarantees every returning verdict has a slot.
//   cand_*        : candidate stream in (valid/ready) plus rand_8_i
//   ber_*_o/i     : BerExp input handshake and operands, result (dval, w)
//   z_val_o/z_o   : accepted z stream, z_rdy_i from consumer
//   reject_o      : one pulse per rejected candidate
//   accept_cnt_o, reject_cnt_o : saturating statistics
//   err_o         : sticky, verdict arrived with nothing pending
// After reset a drain window of BER_LATENCY cycles ignores BerExp results,
// since BerExp has no reset and may still deliver verdicts for pre-reset
// issues. DEPTH must be >= BER_LATENCY+1 and a power of two.
module samplerz_berexp_ctrl import samplerz_pkg::*; #(
  parameter int Z_W         = samplerz_pkg::Z_W,
  parameter int DEPTH       = 16,
  parameter int BER_LATENCY = samplerz_pkg::BER_LATENCY,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cand_val_i,
  output logic             cand_rdy_o,
  input  logic [Z_W-1:0]   cand_z_i,
  input  logic [63:0]      cand_ccs_i,
  input  logic [63:0]      cand_x_i,
  input  logic [7:0]       rand_8_i,
  output logic             ber_val_o,
  input  logic             ber_rdy_i,
  output logic [63:0]      ber_ccs_o,
  output logic [63:0]      ber_x_o,
  output logic [7:0]       ber_rand_o,
  input  logic             ber_dval_i,
  input  logic             ber_w_i,
  output logic             z_val_o,
  input  logic             z_rdy_i,
  output logic [Z_W-1:0]   z_o,
  output logic             reject_o,
  output logic [CNT_W-1:0] accept_cnt_o,
  output logic [CNT_W-1:0] reject_cnt_o,
  output logic             err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = $clog2(BER_LATENCY + 1);

  logic [DW-1:0]  drain_cnt;
  logic           drain;
  logic [AW:0]    pend_cnt, out_cnt;
  logic [AW+1:0]  occ;
  logic           credit;
  logic           issue, res_valid, res_ok, acc_push, out_pop;
  logic [Z_W-1:0] pend_head, out_head;

  assign drain  = (drain_cnt != '0);
  // Registered counts only: an issue this cycle is already visible to the
  // credit check next cycle, so the DEPTH bound cannot be overshot.
  assign occ    = {1'b0, pend_cnt} + {1'b0, out_cnt};
  assign credit = (occ < (AW+2)'(DEPTH));

  assign ber_val_o  = cand_val_i & credit & ~drain;
  assign cand_rdy_o = ber_rdy_i & credit & ~drain;
  assign ber_ccs_o  = cand_ccs_i;
  assign ber_x_o    = cand_x_i;
  assign ber_rand_o = rand_8_i;
  assign issue      = cand_val_i & cand_rdy_o;

  // A verdict with nothing pending is a protocol error and is dropped.
  assign res_valid = ber_dval_i & ~drain;
  assign res_ok    = res_valid & (pend_cnt != '0);
  assign acc_push  = res_ok & ber_w_i;

  assign z_val_o = (out_cnt != '0);
  assign out_pop = z_val_o & z_rdy_i;
  assign z_o     = z_val_o ? out_head : '0;

  sync_fifo_fwft #(.W(Z_W), .DEPTH(DEPTH)) u_pend (
    .clk(clk), .rst(rst), .push(issue), .din(cand_z_i),
    .pop(res_ok), .dout(pend_head), .count(pend_cnt)
  );

  sync_fifo_fwft #(.W(Z_W), .DEPTH(DEPTH)) u_out (
    .clk(clk), .rst(rst), .push(acc_push), .din(pend_head),
    .pop(out_pop), .dout(out_head), .count(out_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      drain_cnt    <= DW'(BER_LATENCY);
      reject_o     <= 1'b0;
      err_o        <= 1'b0;
      accept_cnt_o <= '0;
      reject_cnt_o <= '0;
    end else begin
      if (drain) drain_cnt <= drain_cnt - DW'(1);
      reject_o <= res_ok & ~ber_w_i;
      if (res_valid && pend_cnt == '0) err_o <= 1'b1;
      if (acc_push && accept_cnt_o != '1)
        accept_cnt_o <= accept_cnt_o + CNT_W'(1);
      if (res_ok && !ber_w_i && reject_cnt_o != '1)
        reject_cnt_o <= reject_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_samplerz_berexp_ctrl.sv
module tb_samplerz_berexp_ctrl;

  localparam int Z_W   = 16;
  localparam int DEPTH = 16;
  localparam int LAT   = 12;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                  cand_val_i = 1'b0, cand_rdy_o;
  logic signed [Z_W-1:0] cand_z_i = '0;
  logic [63:0]           cand_ccs_i = '0, cand_x_i = '0;
  logic [7:0]            rand_8_i = '0;
  logic                  ber_val_o, ber_rdy_i = 1'b0;
  logic [63:0]           ber_ccs_o, ber_x_o;
  logic [7:0]            ber_rand_o;
  logic                  ber_dval_i, ber_w_i;
  logic                  z_val_o, z_rdy_i = 1'b0;
  logic signed [Z_W-1:0] z_o;
  logic                  reject_o, err_o;
  logic [CNT_W-1:0]      accept_cnt_o, reject_cnt_o;

  int checks = 0, failures = 0;
  logic signed [Z_W-1:0] exp_q[$];
  logic signed [Z_W-1:0] mon_e;
  int exp_acc = 0, exp_rej = 0, rej_seen = 0;

  // BerExp model: fixed latency, no reset; verdict w is carried in rand bit 0.
  logic [LAT-1:0] pv = '0, pw = '0;
  logic frc_dval = 1'b0, frc_w = 1'b0;
  always @(posedge clk) begin
    pv <= {pv[LAT-2:0], ber_val_o & ber_rdy_i};
    pw <= {pw[LAT-2:0], ber_rand_o[0]};
  end
  assign ber_dval_i = pv[LAT-1] | frc_dval;
  assign ber_w_i    = frc_dval ? frc_w : pw[LAT-1];

  samplerz_berexp_ctrl #(.Z_W(Z_W), .DEPTH(DEPTH), .BER_LATENCY(LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cand_val_i(cand_val_i), .cand_rdy_o(cand_rdy_o), .cand_z_i(cand_z_i),
    .cand_ccs_i(cand_ccs_i), .cand_x_i(cand_x_i), .rand_8_i(rand_8_i),
    .ber_val_o(ber_val_o), .ber_rdy_i(ber_rdy_i), .ber_ccs_o(ber_ccs_o),
    .ber_x_o(ber_x_o), .ber_rand_o(ber_rand_o), .ber_dval_i(ber_dval_i),
    .ber_w_i(ber_w_i), .z_val_o(z_val_o), .z_rdy_i(z_rdy_i), .z_o(z_o),
    .reject_o(reject_o), .accept_cnt_o(accept_cnt_o), .reject_cnt_o(reject_cnt_o),
    .err_o(err_o)
  );

  // Output monitor: each consumed z is compared against the scoreboard.
  always begin
    @(negedge clk); #2;
    if (z_val_o && z_rdy_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL z_unexpected got z_o=%0d, none expected", z_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (z_o !== mon_e) begin
          failures++;
          $display("FAIL z_order got z_o=%0d want %0d", z_o, mon_e);
        end
      end
    end
    if (reject_o === 1'b1) rej_seen++;
  end

  task automatic offer(input logic signed [Z_W-1:0] z, input bit w, input int budget,
                       input bit must, output bit ok, output int waited);
    logic [7:0]  r;
    logic [63:0] c, x;
    @(negedge clk);
    r = 8'($urandom_range(0, 255));
    r[0] = w;
    c = {$urandom, $urandom};
    x = {$urandom, $urandom};
    cand_val_i = 1'b1; cand_z_i = z; rand_8_i = r; cand_ccs_i = c; cand_x_i = x;
    waited = 0;
    #1;
    while (!cand_rdy_o && waited < budget) begin
      @(negedge clk); #1;
      waited++;
    end
    ok = cand_rdy_o;
    if (!ok) begin
      cand_val_i = 1'b0;
      if (must) begin
        checks++; failures++;
        $display("FAIL offer_timeout z=%0d got cand_rdy_o=0 want 1 within %0d cycles", z, budget);
      end
    end else begin
      checks++;
      if (ber_val_o !== 1'b1 || ber_ccs_o !== c || ber_x_o !== x || ber_rand_o !== r) begin
        failures++;
        $display("FAIL passthru got val=%b rand=%h want val=1 rand=%h", ber_val_o, ber_rand_o, r);
      end
      if (w) begin exp_q.push_back(z); exp_acc++; end
      else exp_rej++;
      @(posedge clk); #1;
      cand_val_i = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || pv != '0) && n < 300) begin
      @(posedge clk); n++;
    end
    repeat (3) @(posedge clk);
    checks++;
    if (n >= 300) begin
      failures++;
      $display("FAIL drain_timeout got %0d pending z want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; ber_rdy_i = 1'b1; z_rdy_i = 1'b0; cand_val_i = 1'b0;
    exp_q.delete(); exp_acc = 0; exp_rej = 0; rej_seen = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cand_rdy_o, ber_val_o, z_val_o, reject_o, err_o} !== 5'b0 ||
        accept_cnt_o !== '0 || reject_cnt_o !== '0) begin
      failures++;
      $display("FAIL reset_state got rdy=%b val=%b zval=%b rej=%b err=%b acc=%0d rcnt=%0d want all 0",
               cand_rdy_o, ber_val_o, z_val_o, reject_o, err_o, accept_cnt_o, reject_cnt_o);
    end
  endtask

  task automatic test_drain();
    rst = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (cand_rdy_o !== (k >= LAT)) begin
        failures++;
        $display("FAIL drain_rdy cycle=%0d got cand_rdy_o=%b want %b", k, cand_rdy_o, k >= LAT);
      end
      if (k == 4) begin frc_dval = 1'b1; frc_w = 1'b1; end
      if (k == 5) frc_dval = 1'b0;
    end
    checks++;
    if (err_o !== 1'b0 || z_val_o !== 1'b0 || accept_cnt_o !== '0) begin
      failures++;
      $display("FAIL drain_stale got err=%b zval=%b acc=%0d want 0 0 0", err_o, z_val_o, accept_cnt_o);
    end
  endtask

  task automatic test_basic();
    bit ok; int wt;
    z_rdy_i = 1'b1;
    offer(16'sd5, 1'b1, 5, 1'b1, ok, wt);
    offer(-16'sd3, 1'b0, 5, 1'b1, ok, wt);
    offer(16'sd7, 1'b1, 5, 1'b1, ok, wt);
    repeat (9) @(posedge clk);
    @(negedge clk);
    checks++;
    if (z_val_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_early got z_val_o=%b want 0 one cycle before verdict", z_val_o);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (z_val_o !== 1'b1 || z_o !== 16'sd5) begin
      failures++;
      $display("FAIL basic_latency got z_val_o=%b z_o=%0d want 1 5", z_val_o, z_o);
    end
    wait_drain();
    checks++;
    if (accept_cnt_o !== 32'd2 || reject_cnt_o !== 32'd1 || rej_seen != 1) begin
      failures++;
      $display("FAIL basic_counts got acc=%0d rcnt=%0d pulses=%0d want 2 1 1",
               accept_cnt_o, reject_cnt_o, rej_seen);
    end
  endtask

  task automatic test_full_credit();
    bit ok; int wt; int issued = 0;
    @(negedge clk); z_rdy_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      offer(Z_W'(100 + i), 1'b1, 40, 1'b0, ok, wt);
      if (!ok) break;
      issued++;
    end
    checks++;
    if (issued != DEPTH || cand_rdy_o !== 1'b0 || z_val_o !== 1'b1) begin
      failures++;
      $display("FAIL full_credit got issued=%0d rdy=%b zval=%b want %0d 0 1",
               issued, cand_rdy_o, z_val_o, DEPTH);
    end
    @(negedge clk); z_rdy_i = 1'b1;
    wait_drain();
    offer(16'sd200, 1'b1, 5, 1'b1, ok, wt);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    bit ok; int wt; int stalls = 0;
    for (int i = 0; i < 100; i++) begin
      offer(Z_W'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), 5, 1'b1, ok, wt);
      stalls += wt;
      if (i == 49) begin
        checks++;
        if (dut.pend_cnt !== 5'd12) begin
          failures++;
          $display("FAIL b2b_inflight got %0d want 12", dut.pend_cnt);
        end
      end
    end
    wait_drain();
    checks++;
    if (stalls != 0 || accept_cnt_o !== CNT_W'(exp_acc) || reject_cnt_o !== CNT_W'(exp_rej) ||
        rej_seen != exp_rej) begin
      failures++;
      $display("FAIL b2b_totals got stalls=%0d acc=%0d rcnt=%0d pulses=%0d want 0 %0d %0d %0d",
               stalls, accept_cnt_o, reject_cnt_o, rej_seen, exp_acc, exp_rej, exp_rej);
    end
  endtask

  task automatic test_error();
    @(negedge clk); frc_dval = 1'b1; frc_w = 1'b1;
    @(negedge clk); frc_dval = 1'b0;
    checks++;
    if (err_o !== 1'b1) begin
      failures++;
      $display("FAIL err_set got err_o=%b want 1", err_o);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (err_o !== 1'b1 || z_val_o !== 1'b0 || accept_cnt_o !== CNT_W'(exp_acc)) begin
      failures++;
      $display("FAIL err_hold got err=%b zval=%b acc=%0d want 1 0 %0d", err_o, z_val_o, accept_cnt_o, exp_acc);
    end
    // Blocked BerExp input must hold off issue.
    ber_rdy_i = 1'b0; cand_val_i = 1'b1; #1;
    checks++;
    if (cand_rdy_o !== 1'b0) begin
      failures++;
      $display("FAIL ber_rdy_gate got cand_rdy_o=%b want 0", cand_rdy_o);
    end
    cand_val_i = 1'b0; ber_rdy_i = 1'b1;
  endtask

  task automatic test_mid_reset();
    bit ok; int wt;
    for (int i = 0; i < 8; i++) offer(Z_W'(300 + i), 1'(i % 2), 5, 1'b1, ok, wt);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete(); exp_acc = 0; exp_rej = 0; rej_seen = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (err_o !== 1'b0 || z_val_o !== 1'b0 || accept_cnt_o !== '0 || reject_cnt_o !== '0) begin
      failures++;
      $display("FAIL midrst_clear got err=%b zval=%b acc=%0d rcnt=%0d want 0", err_o, z_val_o,
               accept_cnt_o, reject_cnt_o);
    end
    rst = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (err_o !== 1'b0 || z_val_o !== 1'b0 || accept_cnt_o !== '0 || reject_cnt_o !== '0 ||
        rej_seen != 0) begin
      failures++;
      $display("FAIL midrst_stale got err=%b zval=%b acc=%0d rcnt=%0d pulses=%0d want 0",
               err_o, z_val_o, accept_cnt_o, reject_cnt_o, rej_seen);
    end
    offer(16'sd42, 1'b1, 5, 1'b1, ok, wt);
    wait_drain();
    checks++;
    if (accept_cnt_o !== 32'd1) begin
      failures++;
      $display("FAIL midrst_resume got acc=%0d want 1", accept_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_drain();
    test_basic();
    test_full_credit();
    test_back_to_back();
    test_error();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion want finish within 500000 time units");
    $fatal(1, "watchdog");
  end

endmodule
